// File: rtl/arb_mux_pkg.sv
// arb_mux_nb_nto1 shared types and helpers.
// Mode encoding and channel-index width function.
package arb_mux_pkg;

  typedef enum logic {
    MODE_DIRECT = 1'b0,
    MODE_RR     = 1'b1
  } mode_e;

  function automatic int idx_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/arb_mux_rr_arbiter.sv
// Combinational round-robin arbiter.
// Grants the first requester at or after ptr, modulo N.
module arb_mux_rr_arbiter
  import arb_mux_pkg::*;
#(
  parameter  int p_n  = 8,
  localparam int p_cw = idx_width(p_n)
) (
  input  logic [p_n-1:0]  req,
  input  logic [p_cw-1:0] ptr,
  input  logic            en,
  output logic [p_n-1:0]  grant,
  output logic [p_cw-1:0] gnt_idx,
  output logic            any_grant
);

  // Circular priority search starting at ptr.
  always_comb begin
    int j;
    logic [p_cw-1:0] jj;
    grant     = '0;
    gnt_idx   = '0;
    any_grant = 1'b0;
    j         = 0;
    jj        = '0;
    for (int k = 0; k < p_n; k++) begin
      j = int'(ptr) + k;
      if (j >= p_n) begin
        j = j - p_n;
      end
      jj = p_cw'(j);
      if (en && !any_grant && req[jj]) begin
        any_grant  = 1'b1;
        grant[jj]  = 1'b1;
        gnt_idx    = jj;
      end
    end
  end

endmodule

// File: rtl/arb_mux_nb_nto1.sv
// N-to-1 val/rdy mux, direct-select or round-robin.
// ARB_MUX_XFER_COUNT_EN adds a saturating xfer_count.
module arb_mux_nb_nto1
  import arb_mux_pkg::*;
#(
  parameter  int p_nbits     = 8,
  parameter  int p_nchannels = 8,
  localparam int p_cw        = idx_width(p_nchannels)
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           mode,
  input  logic [p_cw-1:0]                sel,
  input  logic [p_nchannels-1:0]         in_val,
  output logic [p_nchannels-1:0]         in_rdy,
  input  logic [p_nchannels*p_nbits-1:0] in_msg,
  output logic                           out_val,
  input  logic                           out_rdy,
  output logic [p_nbits-1:0]             out_msg,
  output logic [p_cw-1:0]                out_chan
`ifdef ARB_MUX_XFER_COUNT_EN
  ,
  output logic [15:0]                    xfer_count
`endif
);

  logic                   out_val_q, out_val_d;
  logic [p_nbits-1:0]     out_msg_q, out_msg_d;
  logic [p_cw-1:0]        out_chan_q, out_chan_d;
  logic [p_cw-1:0]        rr_ptr_q, rr_ptr_d;

  logic [p_nbits-1:0]     ch_msg [p_nchannels];
  logic [p_nchannels-1:0] rr_grant;
  logic [p_nchannels-1:0] rdy;
  logic [p_cw-1:0]        rr_idx;
  logic [p_cw-1:0]        g;
  logic                   rr_any;
  logic                   rr_en;
  logic                   is_rr;
  logic                   can_accept;
  logic                   sel_ok;
  logic                   xfer;

  for (genvar i = 0; i < p_nchannels; i++) begin : g_unpack
    assign ch_msg[i] = in_msg[i*p_nbits +: p_nbits];
  end

  assign is_rr  = (mode == MODE_RR);
  assign rr_en  = is_rr && !reset;
  assign sel_ok = int'(sel) < p_nchannels;

  arb_mux_rr_arbiter #(
    .p_n (p_nchannels)
  ) u_arb (
    .req       (in_val),
    .ptr       (rr_ptr_q),
    .en        (rr_en),
    .grant     (rr_grant),
    .gnt_idx   (rr_idx),
    .any_grant (rr_any)
  );

  // Ready generation and selected channel index.
  always_comb begin
    can_accept = !out_val_q || out_rdy;
    rdy        = '0;
    g          = '0;
    if (!reset) begin
      if (is_rr) begin
        if (rr_any) begin
          rdy = rr_grant & {p_nchannels{can_accept}};
          g   = rr_idx;
        end
      end else if (sel_ok) begin
        rdy[sel] = can_accept;
        g        = sel;
      end
    end
  end

  assign in_rdy = rdy;
  assign xfer   = |(in_val & rdy);

  // Output register load/drain and pointer advance.
  always_comb begin
    out_val_d  = out_val_q;
    out_msg_d  = out_msg_q;
    out_chan_d = out_chan_q;
    rr_ptr_d   = rr_ptr_q;
    if (xfer) begin
      out_val_d  = 1'b1;
      out_msg_d  = ch_msg[g];
      out_chan_d = g;
      if (is_rr) begin
        if (int'(g) == p_nchannels - 1) begin
          rr_ptr_d = '0;
        end else begin
          rr_ptr_d = g + 1'b1;
        end
      end
    end else if (out_val_q && out_rdy) begin
      out_val_d = 1'b0;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_val_q  <= 1'b0;
      out_msg_q  <= '0;
      out_chan_q <= '0;
      rr_ptr_q   <= '0;
    end else begin
      out_val_q  <= out_val_d;
      out_msg_q  <= out_msg_d;
      out_chan_q <= out_chan_d;
      rr_ptr_q   <= rr_ptr_d;
    end
  end

  assign out_val  = out_val_q;
  assign out_msg  = out_msg_q;
  assign out_chan = out_chan_q;

`ifdef ARB_MUX_XFER_COUNT_EN
  logic [15:0] cnt_q, cnt_d;

  // Saturating count of output-side transfers.
  always_comb begin
    cnt_d = cnt_q;
    if (out_val_q && out_rdy && cnt_q != 16'hFFFF) begin
      cnt_d = cnt_q + 16'd1;
    end
  end

  // Counter register.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign xfer_count = cnt_q;
`endif

endmodule

// File: tb/tb_arb_mux_nb_nto1.sv
// Directed bench for arb_mux_nb_nto1 with a spec-level model.
// Checks every cycle plus literal expectations.
module tb_arb_mux_nb_nto1;

  localparam int N  = 8;
  localparam int W  = 8;
  localparam int CW = 3;

  logic           clk = 1'b0;
  logic           reset;
  logic           mode;
  logic [CW-1:0]  sel;
  logic [N-1:0]   in_val;
  logic [N-1:0]   in_rdy;
  logic [N*W-1:0] in_msg;
  logic           out_val;
  logic           out_rdy;
  logic [W-1:0]   out_msg;
  logic [CW-1:0]  out_chan;
`ifdef ARB_MUX_XFER_COUNT_EN
  logic [15:0]    xfer_count;
  int             m_cnt = 0;
`endif

  int       n_vec = 0;
  int       n_err = 0;
  bit       m_val = 0;
  logic [W-1:0] m_msg = '0;
  int       m_chan = 0;
  int       m_ptr = 0;

  arb_mux_nb_nto1 #(
    .p_nbits     (W),
    .p_nchannels (N)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .mode     (mode),
    .sel      (sel),
    .in_val   (in_val),
    .in_rdy   (in_rdy),
    .in_msg   (in_msg),
    .out_val  (out_val),
    .out_rdy  (out_rdy),
    .out_msg  (out_msg),
    .out_chan (out_chan)
`ifdef ARB_MUX_XFER_COUNT_EN
    ,
    .xfer_count (xfer_count)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Ready vector the rules demand for current inputs and model state.
  function automatic logic [N-1:0] exp_rdy();
    logic [N-1:0] r;
    bit ca;
    bit done;
    r    = '0;
    done = 0;
    ca   = !m_val || out_rdy;
    if (!reset) begin
      if (!mode) begin
        if (int'(sel) < N) r[sel] = ca;
      end else begin
        for (int k = 0; k < N; k++) begin
          int c;
          c = (m_ptr + k) % N;
          if (!done && in_val[c]) begin
            r[c] = ca;
            done = 1;
          end
        end
      end
    end
    return r;
  endfunction

  function automatic int exp_g();
    logic [N-1:0] t;
    int g;
    t = exp_rdy() & in_val;
    g = 0;
    for (int i = 0; i < N; i++) if (t[i]) g = i;
    return g;
  endfunction

  // Model state advances on each rising edge.
  always @(posedge clk) begin
    if (reset) begin
      m_val  <= 0;
      m_msg  <= '0;
      m_chan <= 0;
      m_ptr  <= 0;
`ifdef ARB_MUX_XFER_COUNT_EN
      m_cnt  <= 0;
`endif
    end else begin
`ifdef ARB_MUX_XFER_COUNT_EN
      if (m_val && out_rdy && m_cnt < 65535) m_cnt <= m_cnt + 1;
`endif
      if (|(exp_rdy() & in_val)) begin
        m_val  <= 1;
        m_msg  <= in_msg[exp_g()*W +: W];
        m_chan <= exp_g();
        if (mode) m_ptr <= (exp_g() + 1) % N;
      end else if (m_val && out_rdy) begin
        m_val <= 0;
      end
    end
  end

  // Per-cycle comparison against the model.
  always begin
    @(negedge clk);
    #1;
    chk("in_rdy", 32'(in_rdy), 32'(exp_rdy()));
    chk("out_val", 32'(out_val), 32'(m_val));
    chk("out_msg", 32'(out_msg), 32'(m_msg));
    chk("out_chan", 32'(out_chan), 32'(m_chan));
`ifdef ARB_MUX_XFER_COUNT_EN
    chk("xfer_count", 32'(xfer_count), 32'(m_cnt));
`endif
  end

  task automatic cyc(input bit rst, input bit md, input int s,
                     input logic [N-1:0] v, input bit ordy);
    @(negedge clk);
    reset   = rst;
    mode    = md;
    sel     = CW'(s);
    in_val  = v;
    out_rdy = ordy;
  endtask

  task automatic setmsg(input int i, input logic [W-1:0] d);
    in_msg[i*W +: W] = d;
  endtask

  int seq [3] = '{6, 2, 6};

  initial begin
    reset   = 1;
    mode    = 0;
    sel     = '0;
    in_val  = '0;
    in_msg  = '0;
    out_rdy = 0;

    cyc(1, 1, 0, 8'hFF, 1);
    #2 chk("rst_rdy", 32'(in_rdy), 0);
    chk("rst_val", 32'(out_val), 0);

    cyc(0, 0, 3, 8'h08, 1);
    setmsg(3, 8'hA5);
    #2 chk("d_rdy", 32'(in_rdy), 32'h08);
    cyc(0, 0, 3, 8'h00, 1);
    #2 chk("d_val", 32'(out_val), 1);
    chk("d_msg", 32'(out_msg), 32'hA5);
    chk("d_chan", 32'(out_chan), 3);

    cyc(0, 0, 0, 8'h01, 1);
    setmsg(0, 8'h11);
    for (int k = 0; k < 3; k++) begin
      cyc(0, 0, 0, 8'h01, 0);
      setmsg(0, 8'h22);
      #2 chk("st_rdy", 32'(in_rdy), 0);
      chk("st_msg", 32'(out_msg), 32'h11);
    end
    cyc(0, 0, 0, 8'h01, 1);
    #2 chk("st_rel", 32'(in_rdy), 32'h01);
    cyc(0, 0, 0, 8'h00, 1);
    #2 chk("st_new", 32'(out_msg), 32'h22);

    for (int i = 0; i < N; i++) setmsg(i, W'(8'h10 + i));
    for (int k = 0; k <= 10; k++) begin
      cyc(0, 1, 0, 8'hFF, 1);
      #2;
      if (k > 0) begin
        chk("rr_chan", 32'(out_chan), 32'((k - 1) % 8));
        chk("rr_msg", 32'(out_msg), 32'(8'h10 + (k - 1) % 8));
      end
    end

    for (int k = 0; k <= 3; k++) begin
      cyc(0, 1, 0, 8'h44, 1);
      #2;
      if (k == 0) chk("rr2_rdy", 32'(in_rdy), 32'h40);
      if (k > 0) chk("rr2_chan", 32'(out_chan), 32'(seq[k-1]));
    end

    for (int k = 0; k <= 4; k++) begin
      cyc(0, 0, 5, (k < 4) ? 8'h20 : 8'h00, 1);
      if (k < 4) setmsg(5, W'(k + 1));
      #2;
      if (k > 0) begin
        chk("b2b_val", 32'(out_val), 1);
        chk("b2b_msg", 32'(out_msg), 32'(k));
        chk("b2b_chan", 32'(out_chan), 5);
      end
    end

    cyc(0, 1, 0, 8'h10, 1);
    cyc(1, 1, 0, 8'hFF, 1);
    #2 chk("mr_pre", 32'(out_val), 1);
    chk("mr_rdy", 32'(in_rdy), 0);
    cyc(0, 1, 0, 8'hFF, 1);
    #2 chk("mr_val", 32'(out_val), 0);
    chk("mr_chan", 32'(out_chan), 0);
    chk("mr_grant", 32'(in_rdy), 32'h01);
`ifdef ARB_MUX_XFER_COUNT_EN
    chk("mr_cnt", 32'(xfer_count), 0);
`endif
    cyc(0, 1, 0, 8'h00, 1);
    #2 chk("mr_out", 32'(out_chan), 0);
    chk("mr_omsg", 32'(out_msg), 32'h10);
    chk("mr_oval", 32'(out_val), 1);
    cyc(0, 1, 0, 8'h00, 1);
    #2 chk("drain_val", 32'(out_val), 0);
    chk("drain_hold", 32'(out_msg), 32'h10);

    @(negedge clk);
    #2;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/arb_mux_nb_nto1.md
Name: arb_mux_nb_nto1

Overview:
- Parametrised successor to the combinational 1-bit 8-to-1 mux.
- N channels, each W bits wide, with a val/rdy handshake per channel and one registered output stage.
- Two modes:
  - Direct-select: `sel` picks the channel.
  - Round-robin: arbitrates among valid channels.
- Sits between multiple producers and one consumer, e.g. request funnels into a shared pipeline.

Parameters:
- p_nbits, 8, data width W per channel (1..64)
- p_nchannels, 8, channel count N (2..16); need not be a power of two

Ports:
- clk  input  1  clock; all state updates on rising edge
- reset  input  1  synchronous, active-high reset
- mode  input  1  0 = direct-select, 1 = round-robin
- sel  input  $clog2(N)  channel index used in direct mode
- in_val  input  N  per-channel valid
- in_rdy  output  N  per-channel ready (combinational)
- in_msg  input  N*W  packed channel data; channel i occupies bits [i*W+W-1 : i*W]
- out_val  output  1  output register holds valid data
- out_rdy  input  1  consumer ready
- out_msg  output  W  registered selected data
- out_chan  output  $clog2(N)  index of the channel that produced out_msg

Behaviour:
- Reset: out_val=0, out_msg=0, out_chan=0, rr_ptr=0. All in_rdy=0 while reset is high.
- can_accept = !out_val || out_rdy. This is a one-entry pipelined buffer: full throughput when out_rdy is held high.
- Direct mode:
  - in_rdy[sel] = can_accept; all other in_rdy bits = 0. in_rdy does not depend on in_val.
  - If sel >= N: all in_rdy = 0 and no transfer occurs.
- Round-robin mode:
  - grant = first i with in_val[i]=1, searching rr_ptr, rr_ptr+1, ... modulo N.
  - in_rdy[grant] = can_accept; all other bits 0. All in_rdy = 0 when no channel is valid.
- Transfer:
  - An input transfer occurs when in_val[g] && in_rdy[g].
  - On the next edge: out_msg<=in_msg[g], out_chan<=g, out_val<=1.
  - Latency: exactly 1 cycle from input transfer to out_val.
- Output drain:
  - If out_val && out_rdy and there is no input transfer, out_val<=0.
  - out_msg and out_chan hold their last values.
  - Simultaneous drain and accept in the same cycle: register reloads; out_val stays 1.
- Stall: while out_val && !out_rdy, out_msg and out_chan are stable and all in_rdy = 0.
- rr_ptr update:
  - Only on a round-robin-mode transfer: rr_ptr <= (g+1) mod N. Wraps N-1 -> 0.
  - Unchanged in direct mode and on cycles with no transfer.
- Mode switching: a change of mode or sel takes effect combinationally in the same cycle. Data already in the output register is unaffected.
- Reset mid-operation: buffered data is discarded (out_val=0) and rr_ptr=0 on the next edge.

Optional Feature:
- Macro: ARB_MUX_XFER_COUNT_EN
- When defined:
  - Extra output port xfer_count (16 bits) counts output transfers (out_val && out_rdy).
  - Saturates at 16'hFFFF.
  - Cleared by reset.
- When not defined: the port and counter are absent. Core behaviour is identical.

Decomposition:
- Package arb_mux_pkg:
  - mode enum: MODE_DIRECT=1'b0, MODE_RR=1'b1
  - helper function computing the channel-index width from N
- Sub-module arb_mux_rr_arbiter:
  - Parametrised by N.
  - Inputs: req[N], ptr, en.
  - Outputs: one-hot grant[N], grant index, any_grant.
  - Purely combinational. The parent holds rr_ptr and the output register.

Test Plan (N=8, W=8):
- Direct, sel=3, in_msg[3]=8'hA5, in_val[3]=1, out_rdy=1 -> in_rdy=8'b0000_1000; next cycle out_val=1, out_msg=A5, out_chan=3.
- Stall: output holds 8'h11, out_rdy=0 for 3 cycles, in_val[0]=1 with 8'h22 -> in_rdy=0, out_msg stays 11. out_rdy=1 -> 22 appears the following cycle.
- RR, all in_val=1, channel data = 8'h10+i, out_rdy=1 for 10 cycles -> out_chan sequence 0,1,2,...,7,0,1; out_msg=10+out_chan; rr_ptr wraps after 7.
- RR, only in_val[2] and in_val[6], rr_ptr=3 -> grant 6 first, then 2, then 6.
- Back-to-back throughput: direct sel=5, 4 consecutive valid beats 01,02,03,04, out_rdy=1 -> outputs on 4 consecutive cycles, no bubbles.
- Reset asserted while out_val=1 and rr_ptr=5 -> next cycle out_val=0, out_chan=0; the first RR grant with all channels valid is 0. With ARB_MUX_XFER_COUNT_EN, xfer_count returns to 0.
